// File: rtl/mem_fifo_wr_gate.sv
// Occupancy-aware write gate in front of memory_core in FIFO mode: registers
// accepted words onto the core write port and tracks reserved entries against depth.
module mem_fifo_wr_gate #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          flush,
  input  logic [CW-1:0] depth,
  input  logic [3:0]    almost_count,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] data_out,
  output logic          wen_in,
  input  logic          ren_in,
  input  logic          valid_out,
  output logic [CW-1:0] occupancy,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          underflow_err
);

  logic [DW-1:0] data_q, data_d;
  logic          wen_q, wen_d;
  logic          ren_d1_q, ren_d1_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          uflow_q, uflow_d;
  logic          acc, ret;
  logic [CW:0]   af_sum;

  // rst_n gating keeps in_ready low while the block is held in reset
  assign in_ready = rst_n & clk_en & ~flush & (occ_q < depth);
  assign acc      = clk_en & in_valid & in_ready;
  assign ret      = clk_en & ren_d1_q & valid_out;

  always_comb begin
    data_d   = data_q;
    wen_d    = wen_q;
    ren_d1_d = ren_d1_q;
    occ_d    = occ_q;
    uflow_d  = uflow_q;
    if (clk_en) begin
      if (flush) begin
        wen_d    = 1'b0;
        ren_d1_d = 1'b0;
        occ_d    = '0;
        uflow_d  = 1'b0;
      end else begin
        ren_d1_d = ren_in;
        wen_d    = acc;
        if (acc) data_d = in_data;
        // The slot is reserved on accept, before the write reaches the core
        unique case ({acc, ret})
          2'b10:   occ_d = occ_q + 1'b1;
          2'b01: begin
            if (occ_q == '0) uflow_d = 1'b1;
            else             occ_d   = occ_q - 1'b1;
          end
          default: occ_d = occ_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      wen_q    <= 1'b0;
      ren_d1_q <= 1'b0;
      occ_q    <= '0;
      uflow_q  <= 1'b0;
    end else begin
      data_q   <= data_d;
      wen_q    <= wen_d;
      ren_d1_q <= ren_d1_d;
      occ_q    <= occ_d;
      uflow_q  <= uflow_d;
    end
  end

  // Widened by one bit so occupancy + margin cannot wrap
  assign af_sum        = {1'b0, occ_q} + {{(CW-3){1'b0}}, almost_count};
  assign almost_full   = (af_sum >= {1'b0, depth});
  assign full          = (occ_q >= depth);
  assign empty         = (occ_q == '0);
  assign occupancy     = occ_q;
  assign data_out      = data_q;
  assign wen_in        = wen_q;
  assign underflow_err = uflow_q;

endmodule

// File: tb/tb_mem_fifo_wr_gate.sv
// Directed bench for mem_fifo_wr_gate: fill, retire, same-cycle traffic,
// status thresholds, underflow, flush, clock enable and async reset.
module tb_mem_fifo_wr_gate;

  logic        clk, rst_n, clk_en, flush;
  logic [15:0] depth;
  logic [3:0]  almost_count;
  logic [15:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] data_out;
  logic        wen_in, ren_in, valid_out;
  logic [15:0] occupancy;
  logic        full, empty, almost_full, underflow_err;

  int tests = 0;
  int fails = 0;

  mem_fifo_wr_gate #(.DW(16), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .depth(depth), .almost_count(almost_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .wen_in(wen_in),
    .ren_in(ren_in), .valid_out(valid_out),
    .occupancy(occupancy), .full(full), .empty(empty),
    .almost_full(almost_full), .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++; if (data_out !== 16'h0) begin fails++; $display("FAIL reset_data: got %h expected 0000", data_out); end
    tests++; if (wen_in !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b expected 0", wen_in); end
    tests++; if (occupancy !== 16'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
    tests++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL reset_uflow: got %b expected 0", underflow_err); end
  endtask

  task automatic test_fill();
    logic        exp_rdy, exp_wen;
    logic [15:0] exp_data, exp_occ;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h10 + 16'(i);
      #1;
      exp_rdy = (i < 4);
      tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, in_ready, exp_rdy); end
      cyc();
      exp_wen  = (i < 4);
      exp_data = (i < 4) ? 16'h10 + 16'(i) : 16'h13;
      exp_occ  = (i < 4) ? 16'(i + 1) : 16'd4;
      tests++; if (wen_in !== exp_wen) begin fails++; $display("FAIL fill_wen[%0d]: got %b expected %b", i, wen_in, exp_wen); end
      tests++; if (data_out !== exp_data) begin fails++; $display("FAIL fill_data[%0d]: got %h expected %h", i, data_out, exp_data); end
      tests++; if (occupancy !== exp_occ) begin fails++; $display("FAIL fill_occ[%0d]: got %0d expected %0d", i, occupancy, exp_occ); end
    end
    in_valid = 1'b0;
    #1;
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b expected 1", full); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL fill_empty: got %b expected 0", empty); end
    cyc();
  endtask

  task automatic test_retire();
    ren_in = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ret_ready_m: got %b expected 0", in_ready); end
    cyc();
    ren_in = 1'b0; valid_out = 1'b1;
    #1;
    tests++; if (occupancy !== 16'd4) begin fails++; $display("FAIL ret_occ_m1: got %0d expected 4", occupancy); end
    cyc();
    valid_out = 1'b0;
    #1;
    tests++; if (occupancy !== 16'd3) begin fails++; $display("FAIL ret_occ_m2: got %0d expected 3", occupancy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ret_ready_m2: got %b expected 1", in_ready); end
    in_valid = 1'b1; in_data = 16'h20;
    cyc();
    in_valid = 1'b0;
    #1;
    tests++; if (occupancy !== 16'd4) begin fails++; $display("FAIL ret_occ_refill: got %0d expected 4", occupancy); end
    tests++; if (wen_in !== 1'b1 || data_out !== 16'h20) begin fails++; $display("FAIL ret_write: got wen=%b data=%h expected wen=1 data=0020", wen_in, data_out); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ret_ready_full: got %b expected 0", in_ready); end
    cyc();
  endtask

  task automatic test_same_cycle();
    ren_in = 1'b1;
    cyc();
    valid_out = 1'b1;
    cyc();
    ren_in = 1'b0;
    cyc();
    ren_in = 1'b1; valid_out = 1'b0;
    cyc();
    tests++; if (occupancy !== 16'd2) begin fails++; $display("FAIL same_pre_occ: got %0d expected 2", occupancy); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'h30 + 16'(i); valid_out = 1'b1; ren_in = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL same_ready[%0d]: got %b expected 1", i, in_ready); end
      cyc();
      tests++; if (occupancy !== 16'd2) begin fails++; $display("FAIL same_occ[%0d]: got %0d expected 2", i, occupancy); end
      tests++; if (wen_in !== 1'b1 || data_out !== 16'h30 + 16'(i)) begin fails++; $display("FAIL same_write[%0d]: got wen=%b data=%h expected wen=1 data=%h", i, wen_in, data_out, 16'h30 + 16'(i)); end
    end
    in_valid = 1'b0; valid_out = 1'b0; ren_in = 1'b0;
    cyc();
  endtask

  task automatic test_almost_full();
    logic exp_af, exp_full;
    flush = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL af_flush_ready: got %b expected 0", in_ready); end
    cyc();
    flush = 1'b0; depth = 16'd8; almost_count = 4'd3;
    #1;
    tests++; if (occupancy !== 16'd0 || almost_full !== 1'b0) begin fails++; $display("FAIL af_start: got occ=%0d af=%b expected occ=0 af=0", occupancy, almost_full); end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'h40 + 16'(i);
      cyc();
      exp_af   = (i + 1 >= 5);
      exp_full = (i + 1 >= 8);
      tests++; if (almost_full !== exp_af) begin fails++; $display("FAIL af_almost[occ=%0d]: got %b expected %b", i + 1, almost_full, exp_af); end
      tests++; if (full !== exp_full) begin fails++; $display("FAIL af_full[occ=%0d]: got %b expected %b", i + 1, full, exp_full); end
    end
    in_valid = 1'b0;
    #1;
    tests++; if (occupancy !== 16'd8 || in_ready !== 1'b0) begin fails++; $display("FAIL af_end: got occ=%0d rdy=%b expected occ=8 rdy=0", occupancy, in_ready); end
    cyc();
  endtask

  task automatic test_depth_zero();
    flush = 1'b1;
    cyc();
    flush = 1'b0; depth = 16'd0; almost_count = 4'd0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'hAA;
      #1;
      tests++; if (in_ready !== 1'b0 || full !== 1'b1) begin fails++; $display("FAIL d0_status[%0d]: got rdy=%b full=%b expected rdy=0 full=1", i, in_ready, full); end
      cyc();
      tests++; if (occupancy !== 16'd0 || wen_in !== 1'b0) begin fails++; $display("FAIL d0_state[%0d]: got occ=%0d wen=%b expected occ=0 wen=0", i, occupancy, wen_in); end
    end
    in_valid = 1'b0; depth = 16'd4;
    cyc();
  endtask

  task automatic test_underflow();
    ren_in = 1'b1;
    cyc();
    ren_in = 1'b0; valid_out = 1'b1;
    #1;
    tests++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL uf_before: got %b expected 0", underflow_err); end
    cyc();
    valid_out = 1'b0;
    #1;
    tests++; if (underflow_err !== 1'b1 || occupancy !== 16'd0) begin fails++; $display("FAIL uf_set: got uf=%b occ=%0d expected uf=1 occ=0", underflow_err, occupancy); end
    cyc();
    tests++; if (underflow_err !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b expected 1", underflow_err); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    tests++; if (underflow_err !== 1'b0) begin fails++; $display("FAIL uf_flush: got %b expected 0", underflow_err); end
    cyc();
  endtask

  task automatic test_flush_inflight();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h50 + 16'(i);
      cyc();
    end
    tests++; if (occupancy !== 16'd3 || wen_in !== 1'b1) begin fails++; $display("FAIL fl_pre: got occ=%0d wen=%b expected occ=3 wen=1", occupancy, wen_in); end
    flush = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fl_ready: got %b expected 0", in_ready); end
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tests++; if (occupancy !== 16'd0 || wen_in !== 1'b0) begin fails++; $display("FAIL fl_clear: got occ=%0d wen=%b expected occ=0 wen=0", occupancy, wen_in); end
    tests++; if (data_out !== 16'h52) begin fails++; $display("FAIL fl_data_hold: got %h expected 0052", data_out); end
    cyc();
  endtask

  task automatic test_clk_en();
    in_valid = 1'b1; in_data = 16'h60;
    cyc();
    in_data = 16'h61; clk_en = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ce_ready: got %b expected 0", in_ready); end
    cyc();
    tests++; if (wen_in !== 1'b1 || occupancy !== 16'd1 || data_out !== 16'h60) begin fails++; $display("FAIL ce_hold: got wen=%b occ=%0d data=%h expected wen=1 occ=1 data=0060", wen_in, occupancy, data_out); end
    clk_en = 1'b1; in_valid = 1'b0;
    cyc();
    tests++; if (wen_in !== 1'b0 || occupancy !== 16'd1) begin fails++; $display("FAIL ce_resume: got wen=%b occ=%0d expected wen=0 occ=1", wen_in, occupancy); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 16'h70;
    cyc();
    in_data = 16'h71;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (data_out !== 16'h0 || wen_in !== 1'b0) begin fails++; $display("FAIL ar_write: got wen=%b data=%h expected wen=0 data=0000", wen_in, data_out); end
    tests++; if (occupancy !== 16'd0 || underflow_err !== 1'b0) begin fails++; $display("FAIL ar_state: got occ=%0d uf=%b expected occ=0 uf=0", occupancy, underflow_err); end
    tests++; if (in_ready !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL ar_status: got rdy=%b empty=%b expected rdy=0 empty=1", in_ready, empty); end
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    tests++; if (occupancy !== 16'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL ar_release: got occ=%0d rdy=%b expected occ=0 rdy=1", occupancy, in_ready); end
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0;
    depth = 16'd4; almost_count = 4'd0;
    in_data = 16'h0; in_valid = 1'b0; ren_in = 1'b0; valid_out = 1'b0;
    #2;
    test_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    test_fill();
    test_retire();
    test_same_cycle();
    test_almost_full();
    test_depth_zero();
    test_underflow();
    test_flush_inflight();
    test_clk_en();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
